// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
//   mult_op_e      : RISC-V M-extension multiply op encoding
//   mult_state_e   : control FSM states
//   booth_digit_e  : decoded radix-4 Booth digit
//   booth_decode() : maps a 3-bit multiplier window to a Booth digit
//   a_is_signed() / b_is_signed() : operand signedness per op
package mult_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mult_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mult_state_e;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_POS1 = 3'd1,
        BD_POS2 = 3'd2,
        BD_NEG1 = 3'd3,
        BD_NEG2 = 3'd4
    } booth_digit_e;

    // Window is {b[i+1], b[i], b[i-1]}; digit = -2*b[i+1] + b[i] + b[i-1].
    function automatic booth_digit_e booth_decode(input logic [2:0] bits);
        booth_digit_e d;
        case (bits)
            3'b001, 3'b010: d = BD_POS1;
            3'b011:         d = BD_POS2;
            3'b100:         d = BD_NEG2;
            3'b101, 3'b110: d = BD_NEG1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

    function automatic logic a_is_signed(input mult_op_e o);
        return (o == OP_MULH) || (o == OP_MULHSU);
    endfunction

    function automatic logic b_is_signed(input mult_op_e o);
        return (o == OP_MULH);
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Handshake bundle for booth_mult_seq.
//   in_valid/in_ready  : operand handshake (op_a, op_b, op)
//   flush              : abort the operation in flight
//   out_valid/out_ready: result handshake (result, product)
//   busy               : multiplier not idle
// Modports: master = pipeline side, slave = multiplier side.
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [1:0]           op;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, op_a, op_b, op, flush, out_ready,
        input  in_ready, out_valid, result, product, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, op, flush, out_ready,
        output in_ready, out_valid, result, product, busy
    );
endinterface

// File: rtl/booth_r4_digit.sv
// Combinational radix-4 Booth partial-product selector.
//   bits  : 3-bit multiplier window {b[i+1], b[i], b[i-1]}
//   mcand : multiplicand, already extended to 2*WIDTH
//   pp    : selected partial product 0, +/-M, +/-2M (mod 2^(2*WIDTH))
module booth_r4_digit
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         bits,
    input  logic [2*WIDTH-1:0] mcand,
    output logic [2*WIDTH-1:0] pp
);

    always_comb begin
        pp = '0;
        case (booth_decode(bits))
            BD_POS1: pp = mcand;
            BD_POS2: pp = mcand << 1;
            BD_NEG1: pp = -mcand;
            BD_NEG2: pp = -(mcand << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU.
// Retires two multiplier bits per cycle over ITER iterations, then holds
// the result until the consumer takes it.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : booth_mult_seq_if.slave (operand/result handshakes, flush, busy)
// Optional build macro MULT_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all-zeros or all-ones (variable latency, same result).
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = (WIDTH + 2) / 2
) (
    input  logic           clk,
    input  logic           rst_n,
    booth_mult_seq_if.slave bus
);

    localparam int PW    = 2 * WIDTH;
    localparam int MW    = WIDTH + 3;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    mult_state_e      state;
    mult_state_e      state_nxt;
    mult_op_e         op_q;
    mult_op_e         op_in;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    pp;
    logic [MW-1:0]    mplier;
    logic [MW-1:0]    mplier_shr;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_iter;
    logic             calc_done;
    logic             a_ext;
    logic             b_ext;

    assign op_in  = mult_op_e'(bus.op);
    assign accept = bus.in_valid && bus.in_ready;

    // Sign bits used to widen the operands; zero for unsigned operands.
    assign a_ext = a_is_signed(op_in) & bus.op_a[WIDTH-1];
    assign b_ext = b_is_signed(op_in) & bus.op_b[WIDTH-1];

    assign mplier_shr = {{2{mplier[MW-1]}}, mplier[MW-1:2]};
    assign last_iter  = (cnt == LAST_CNT);

`ifdef MULT_EARLY_TERM_EN
    // Remaining multiplier all-zeros or all-ones produces only zero digits.
    assign calc_done = last_iter || (~|mplier_shr) || (&mplier_shr);
`else
    assign calc_done = last_iter;
`endif

    booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
        .bits  (mplier[2:0]),
        .mcand (mcand),
        .pp    (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = CALC;
            CALC:    if (calc_done)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
        // Flush aborts from any state and suppresses any output.
        if (bus.flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= OP_MUL;
        end else if (accept && !bus.flush) begin
            mcand  <= {{WIDTH{a_ext}}, bus.op_a};
            mplier <= {{2{b_ext}}, bus.op_b, 1'b0};
            acc    <= '0;
            cnt    <= '0;
            op_q   <= op_in;
        end else if (state == CALC && !bus.flush) begin
            acc    <= acc + pp;
            mcand  <= mcand << 2;
            mplier <= mplier_shr;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // in_ready is held low while reset is asserted, not just in IDLE.
    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.product   = acc;
    assign bus.result    = (op_q == OP_MUL) ? acc[WIDTH-1:0] : acc[PW-1:WIDTH];

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=32): directed corner cases,
// back-pressure, flush, reset mid-operation, and randomized ops compared
// against an arithmetic reference model.
module tb_booth_mult_seq;

    localparam int W       = 32;
    localparam int NITER   = (W + 2) / 2;
    localparam int LAT_MAX = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    booth_mult_seq_if #(.WIDTH(W)) bus();

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0]   got_res;
    logic [2*W-1:0] got_prod;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full 2W-bit product: extend each operand per op, multiply mod 2^64.
    function automatic logic [2*W-1:0] ref_prod(input logic [1:0] o,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] ax;
        logic [2*W-1:0] bx;
        ax = (o == 2'b01 || o == 2'b10) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        bx = (o == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ax * bx;
    endfunction

`ifdef MULT_EARLY_TERM_EN
    // Fewest digit pairs after which the rest of 2*b (as a signed value)
    // is 0 or -1.
    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
        longint bv;
        bv = (o == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
        bv = bv * 2;
        for (int k = 1; k <= NITER; k++) begin
            if ((bv >>> (2 * k)) == 0 || (bv >>> (2 * k)) == -1) return k;
        end
        return NITER;
    endfunction
`endif

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
        logic [2*W-1:0] ep;
        logic [W-1:0]   er;
        int lat;
        int el;
        ep = ref_prod(o, a, b);
        er = (o == 2'b00) ? ep[W-1:0] : ep[2*W-1:W];
`ifdef MULT_EARLY_TERM_EN
        el = exp_lat(o, b);
`else
        el = NITER;
`endif
        @(negedge clk);
        bus.op = o; bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1;
        chk("in_ready_idle", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op_a = $urandom; bus.op_b = $urandom; bus.op = 2'($urandom);
        chk("busy_after_accept", bus.busy, 1);
        lat = 0;
        while (!bus.out_valid && lat < LAT_MAX) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, el);
        got_res  = bus.result;
        got_prod = bus.product;
        chk("result", bus.result, er);
        chk("product", bus.product, ep);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_result", bus.result, er);
            chk("hold_product", bus.product, ep);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("valid_after_hs", bus.out_valid, 0);
        chk("busy_after_hs", bus.busy, 0);
        chk("in_ready_after_hs", bus.in_ready, 1);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        logic [1:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;

        bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op = 2'b00;
        bus.flush = 1'b0; bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_product", bus.product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);

        // Directed corner cases
        do_op(2'b00, 32'd7, 32'd6, 0);
        chk("mul7x6_result", got_res, 64'd42);
        chk("mul7x6_product", got_prod, 64'h2A);
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        chk("mulh_min_result", got_res, 64'h4000_0000);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mulhu_max_result", got_res, 64'hFFFF_FFFE);
        chk("mulhu_max_product", got_prod, 64'hFFFF_FFFE_0000_0001);
        do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mulhsu_product", got_prod, 64'hFFFF_FFFF_0000_0001);
        chk("mulhsu_result", got_res, 64'hFFFF_FFFF);
        do_op(2'b11, 32'h1234_5678, 32'd3, 0);
        do_op(2'b11, 32'h1234_5678, 32'd0, 0);
        do_op(2'b01, 32'h1234_5678, 32'hFFFF_FFFF, 0);
        chk("mulh_neg1_product", got_prod, 64'hFFFF_FFFF_EDCB_A988);

        // Back-pressure for 5 cycles
        do_op(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5);

        // Flush at iteration 5
        @(negedge clk);
        bus.op = 2'b00; bus.op_a = 32'd1000; bus.op_b = 32'd2000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        watch_no_valid("flush_no_output", 25);

        // Reset asserted at iteration 3 of a new op
        @(negedge clk);
        bus.op = 2'b11; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_product", bus.product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_in_ready", bus.in_ready, 1);
        watch_no_valid("midrst_no_output", 25);

        // Flush in the same cycle as an accept
        @(negedge clk);
        bus.op = 2'b00; bus.op_a = 32'd5; bus.op_b = 32'd9;
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_accept_busy", bus.busy, 0);
        chk("flush_accept_in_ready", bus.in_ready, 1);
        watch_no_valid("flush_accept_no_output", 25);

        // Randomized ops with biased operands
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       a = '0;
                1:       a = '1;
                2:       a = 32'h8000_0000;
                3:       a = 32'($urandom_range(0, 15));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = '1;
                2:       b = 32'h8000_0000;
                3:       b = 32'($urandom_range(0, 255));
                default: b = $urandom;
            endcase
            do_op(o, a, b, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Sequential radix-4 Booth multiplier, parametrised in operand width, serving the RISC-V M-extension multiply ops (MUL, MULH, MULHSU, MULHU) behind valid/ready handshakes. It sits in the execute stage beside the ALU and replaces the single-shot 32x32 combinational multiplier. It retires two multiplier bits per cycle and holds its result under back-pressure. A flush input lets the pipeline abort an operation in flight.

## Interface
- `WIDTH`, default 32: operand width, even, ≥ 4.
- `ITER`, default (WIDTH+2)/2: iteration count, derived; do not override.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands and op valid.
- `in_ready` output 1: block can accept; high only in IDLE.
- `op_a` input WIDTH: multiplicand (rs1).
- `op_b` input WIDTH: multiplier (rs2).
- `op` input 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `flush` input 1: abort current operation.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `result` output WIDTH: low half for MUL, high half otherwise.
- `product` output 2*WIDTH: full product, debug/verification.
- `busy` output 1: state is not IDLE.

## Operation
- Signedness is decided by `op`:
  - a is signed for MULH and MULHSU.
  - b is signed for MULH only.
  - MUL is treated as unsigned; its low half is identical either way.
- On accept (`in_valid && in_ready`):
  - Extend a to 2*WIDTH (sign or zero) into the multiplicand register.
  - Extend b to WIDTH+2 bits, append a 0 LSB, and store it in the multiplier register (WIDTH+3 bits).
  - Clear the accumulator (2*WIDTH).
  - Latch `op`.
- Each CALC cycle:
  - Booth digit from multiplier[2:0] ∈ {-2,-1,0,+1,+2}.
  - Accumulator += digit × multiplicand, taken mod 2^(2*WIDTH).
  - Multiplicand shifts left 2.
  - Multiplier shifts right 2, arithmetic.
- `product` = accumulator; `result` = `op`==MUL ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH].
- FSM states and transitions:
  - IDLE → CALC on accept.
  - CALC → DONE after the last iteration.
  - DONE → IDLE on `out_valid && out_ready`.
  - Any state → IDLE on `flush`. Flush wins over every other event and produces no output.

## Timing
- Reset values:
  - `in_ready`=0 while `rst_n` is low, 1 after release (IDLE).
  - `out_valid`=0, `busy`=0, `result`=0, `product`=0.
  - All internal registers are 0 and the state is IDLE.
- Latency, with the accept at edge E0:
  - Iterations run on edges E1..E_ITER.
  - `out_valid` goes high after E_ITER: 17 edges for WIDTH=32.
- Back-to-back: a new accept is possible no earlier than the edge after the output handshake. There is no overlap.
- `result` and `product` stay stable while `out_valid && !out_ready`, for any number of cycles.
- A flush in the same cycle as an accept drops the operation; the block stays IDLE.
- Reset asserted mid-operation clears everything immediately. No output is produced.
- Inputs other than `in_valid` are don't-care outside the accept cycle.

## Configuration
- `MULT_EARLY_TERM_EN` defined:
  - After each iteration, if the shifted multiplier register (WIDTH+3 bits) is all-zeros or all-ones, go to DONE on that edge.
  - Latency becomes 1..ITER edges.
- Not defined: always exactly ITER iterations; fixed latency.
- Results are identical in both builds.

## Structure
- `mult_pkg` holds:
  - `mult_op_e`: MUL, MULH, MULHSU, MULHU.
  - `mult_state_e`: IDLE, CALC, DONE.
  - Booth digit encoding constants.
- Sub-module `booth_r4_digit`: combinational. Takes 3 multiplier bits and the multiplicand; outputs the selected partial product (0, ±M, ±2M) at 2*WIDTH.
- The top level holds the FSM, the registers and the iteration counter ($clog2(ITER+1) bits).

## Test plan
- MUL 7×6 → `result`=42, `product`=0x2A. Without `MULT_EARLY_TERM_EN`, `out_valid` 17 edges after accept.
- MULH 0x80000000×0x80000000 → `result`=0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → `result`=0xFFFFFFFE, `product`=0xFFFFFFFE00000001.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → `product`=0xFFFFFFFF00000001, `result`=0xFFFFFFFF.
- Hold `out_ready`=0 for 5 cycles after `out_valid`:
  - `result` is stable and `in_ready` stays 0.
  - On the handshake, IDLE and `in_ready`=1 the next cycle.
- `flush` at iteration 5, then `rst_n` low at iteration 3 of a new op:
  - No `out_valid`.
  - IDLE, `in_ready`=1 on the next cycle.
  - All outputs 0 after reset.
- `MULT_EARLY_TERM_EN` latencies:
  - MULHU with b=3 → `out_valid` after 2 iteration edges.
  - b=0 → 1 edge.
  - MULH with b=0xFFFFFFFF → 1 edge, `product`=-a.
  - Random ops must match a reference model.
